// File: rtl/counter_ctrl_pkg.sv
// Shared types and defaults for the counter command sequencer.
// Latency: n/a. Backpressure: n/a.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int PRESCALE_W_DEF  = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W           = 4;

    // One-shot terminal condition against the counter feedback
    function automatic logic limit_hit(input logic             oneshot,
                                       input logic [CNT_W-1:0] fb,
                                       input logic [CNT_W-1:0] lim);
        return oneshot && (fb == lim);
    endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Button, configuration, feedback and strobe signals between the sequencer and its environment.
// Latency: n/a. Backpressure: none, strobes are fire-and-forget.
interface counter_ctrl_if
    import counter_ctrl_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF
);
    logic                  Btn_start;
    logic                  Btn_stop;
    logic                  Btn_dir;
    logic                  Btn_load;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  Mode_oneshot;
    logic [CNT_W-1:0]      Limit;
    logic [CNT_W-1:0]      Count_fb;
    logic                  Load;
    logic                  Count_en;
    logic                  Up;
    logic                  Running;
    logic                  Done;

    modport master (
        output Btn_start, Btn_stop, Btn_dir, Btn_load,
        output Prescale, Mode_oneshot, Limit, Count_fb,
        input  Load, Count_en, Up, Running, Done
    );

    modport slave (
        input  Btn_start, Btn_stop, Btn_dir, Btn_load,
        input  Prescale, Mode_oneshot, Limit, Count_fb,
        output Load, Count_en, Up, Running, Done
    );
endinterface

// File: rtl/counter_ctrl_edge_sync.sv
// Synchronizes one asynchronous button and emits a one-cycle pulse on its rising edge.
// Latency: pulse valid SYNC_STAGES edges after first sample high. Backpressure: none.
module counter_ctrl_edge_sync
    import counter_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic Clk,
    input  logic nReset,
    input  logic Async_in,
    output logic Pulse
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Held button gives a single pulse: only the 0->1 transition of the synced level fires
    assign Pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/counter_ctrl.sv
// Start/stop/load sequencer with prescaled count strobes and one-shot limit halt for a 4-bit counter.
// Latency: commands act SYNC_STAGES+1 edges after sampling; first Count_en Prescale+1 cycles after RUN. Backpressure: none.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int PRESCALE_W  = PRESCALE_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic           Clk,
    input  logic           nReset,
    counter_ctrl_if.slave  bus
);
    logic [3:0] btn_vec;
    logic [3:0] pulse_vec;
    logic       start_p;
    logic       stop_p;
    logic       dir_p;
    logic       load_p;

    state_t                state_q;
    logic [PRESCALE_W-1:0] presc_q;
    logic                  load_q;
    logic                  count_en_q;
    logic                  up_q;
    logic                  running_q;
    logic                  done_q;

    assign btn_vec = {bus.Btn_load, bus.Btn_dir, bus.Btn_stop, bus.Btn_start};

    counter_ctrl_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync [3:0] (
        .Clk      (Clk),
        .nReset   (nReset),
        .Async_in (btn_vec),
        .Pulse    (pulse_vec)
    );

    assign start_p = pulse_vec[0];
    assign stop_p  = pulse_vec[1];
    assign dir_p   = pulse_vec[2];
    assign load_p  = pulse_vec[3];

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            load_q     <= 1'b0;
            count_en_q <= 1'b0;
            up_q       <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            load_q     <= 1'b0;
            count_en_q <= 1'b0;

            if (dir_p) begin
                up_q <= ~up_q;
            end

            // Load wins over everything and is honoured from any state
            if (load_p) begin
                state_q   <= ST_LOAD;
                load_q    <= 1'b1;
                running_q <= 1'b0;
                done_q    <= 1'b0;
                presc_q   <= '0;
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        state_q <= ST_IDLE;
                    end
                    ST_IDLE, ST_DONE: begin
                        if (start_p) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                            done_q    <= 1'b0;
                            presc_q   <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (stop_p) begin
                            state_q   <= ST_IDLE;
                            running_q <= 1'b0;
                            presc_q   <= '0;
                        end else if (presc_q == bus.Prescale) begin
                            presc_q <= '0;
                            // Count_fb already reflects the previous strobe (counter updates on falling edge)
                            if (limit_hit(bus.Mode_oneshot, bus.Count_fb, bus.Limit)) begin
                                state_q   <= ST_DONE;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                            end else begin
                                count_en_q <= 1'b1;
                            end
                        end else begin
                            // Lowering Prescale below the count lets this run to max and wrap
                            presc_q <= presc_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.Load     = load_q;
    assign bus.Count_en = count_en_q;
    assign bus.Up       = up_q;
    assign bus.Running  = running_q;
    assign bus.Done     = done_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with a falling-edge 4-bit up/down counter model on the feedback path.
module tb_counter_ctrl;

    logic       Clk;
    logic       nReset;
    logic [3:0] btns;     // {load, dir, stop, start}
    logic [7:0] prescale;
    logic       oneshot;
    logic [3:0] limit;
    logic [3:0] ld_val;
    logic [3:0] cnt;

    int checks;
    int errors;

    counter_ctrl_if #(.PRESCALE_W(8)) bus ();

    assign bus.Btn_start    = btns[0];
    assign bus.Btn_stop     = btns[1];
    assign bus.Btn_dir      = btns[2];
    assign bus.Btn_load     = btns[3];
    assign bus.Prescale     = prescale;
    assign bus.Mode_oneshot = oneshot;
    assign bus.Limit        = limit;
    assign bus.Count_fb     = cnt;

    counter_ctrl #(.PRESCALE_W(8), .SYNC_STAGES(2)) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Downstream counter: samples strobes on the falling edge
    always @(negedge Clk or negedge nReset) begin
        if (!nReset)          cnt <= 4'd0;
        else if (bus.Load)    cnt <= ld_val;
        else if (bus.Count_en) cnt <= bus.Up ? cnt + 4'd1 : cnt - 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic set_btns(input logic [3:0] v);
        @(negedge Clk);
        btns = v;
    endtask

    task automatic wait_ce(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (bus.Count_en) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int  n_ce;
        int  n_ld;
        bit  ok;
        logic [3:0] exp_dn [3];

        checks   = 0;
        errors   = 0;
        nReset   = 1'b0;
        btns     = 4'b0000;
        prescale = 8'd3;
        oneshot  = 1'b0;
        limit    = 4'd0;
        ld_val   = 4'd13;

        // Reset state
        tick(2);
        chk("rst_load",    32'(bus.Load),     32'd0);
        chk("rst_ce",      32'(bus.Count_en), 32'd0);
        chk("rst_up",      32'(bus.Up),       32'd1);
        chk("rst_running", 32'(bus.Running),  32'd0);
        chk("rst_done",    32'(bus.Done),     32'd0);
        @(negedge Clk);
        nReset = 1'b1;
        tick(2);

        // Load 13 from IDLE
        set_btns(4'b1000);
        tick(2);
        chk("ld_lat", 32'(bus.Load), 32'd0);
        tick(1);
        chk("ld_pulse", 32'(bus.Load), 32'd1);
        tick(1);
        chk("ld_end", 32'(bus.Load), 32'd0);
        set_btns(4'b0000);
        tick(2);
        chk("ld_cnt", 32'(cnt), 32'd13);

        // Free run, Prescale=3: strobe every 4th cycle, wrap 15->0
        set_btns(4'b0001);
        tick(3);
        chk("run_entry", 32'(bus.Running), 32'd1);
        set_btns(4'b0000);
        n_ce = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (k == 3) chk("ce_off3", 32'(bus.Count_en), 32'd0);
            if (k == 4) chk("ce_off4", 32'(bus.Count_en), 32'd1);
            if (bus.Count_en) n_ce++;
        end
        chk("ce_count20", 32'(n_ce), 32'd5);

        // Direction toggle with counter at 2
        set_btns(4'b0100);
        tick(1);
        chk("wrap_cnt", 32'(cnt), 32'd2);
        chk("wrap_running", 32'(bus.Running), 32'd1);
        tick(2);
        chk("dir_up0", 32'(bus.Up), 32'd0);
        set_btns(4'b0000);
        exp_dn[0] = 4'd1;
        exp_dn[1] = 4'd0;
        exp_dn[2] = 4'd15;
        for (int j = 0; j < 3; j++) begin
            wait_ce(ok);
            chk("dn_ce_seen", 32'(ok), 32'd1);
            @(negedge Clk);
            #1;
            chk("dn_cnt", 32'(cnt), 32'(exp_dn[j]));
        end

        // Load during RUN, button held: one Load cycle, then IDLE
        ld_val = 4'd0;
        set_btns(4'b1000);
        n_ld = 0;
        n_ce = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (i == 2) begin
                chk("rl_load",    32'(bus.Load),     32'd1);
                chk("rl_ce",      32'(bus.Count_en), 32'd0);
                chk("rl_running", 32'(bus.Running),  32'd0);
            end
            if (bus.Load) n_ld++;
            if (i >= 2 && bus.Count_en) n_ce++;
        end
        chk("rl_n_load", 32'(n_ld), 32'd1);
        chk("rl_n_ce",   32'(n_ce), 32'd0);
        chk("rl_cnt",    32'(cnt),  32'd0);
        set_btns(4'b0000);
        tick(2);

        // One-shot up to 5 at Prescale=0
        prescale = 8'd0;
        oneshot  = 1'b1;
        limit    = 4'd5;
        set_btns(4'b0100);
        tick(3);
        chk("dir_up1", 32'(bus.Up), 32'd1);
        set_btns(4'b0001);
        n_ce = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (bus.Count_en) n_ce++;
            if (bus.Done) break;
        end
        chk("os_n_ce",    32'(n_ce),        32'd5);
        chk("os_done",    32'(bus.Done),    32'd1);
        chk("os_running", 32'(bus.Running), 32'd0);
        chk("os_cnt",     32'(cnt),         32'd5);
        set_btns(4'b0000);
        tick(2);

        // Restart from DONE with Count_fb==Limit: no strobe, back to DONE
        set_btns(4'b0001);
        n_ce = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.Count_en) n_ce++;
        end
        chk("os2_n_ce", 32'(n_ce),     32'd0);
        chk("os2_done", 32'(bus.Done), 32'd1);
        chk("os2_cnt",  32'(cnt),      32'd5);
        set_btns(4'b0000);

        // Back to IDLE, then start+stop+load together
        ld_val = 4'd5;
        set_btns(4'b1000);
        tick(4);
        set_btns(4'b0000);
        tick(3);
        set_btns(4'b1011);
        n_ld = 0;
        n_ce = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (i == 2) chk("sim_load", 32'(bus.Load), 32'd1);
            if (bus.Load) n_ld++;
            if (bus.Count_en) n_ce++;
        end
        chk("sim_n_load",  32'(n_ld),        32'd1);
        chk("sim_n_ce",    32'(n_ce),        32'd0);
        chk("sim_running", 32'(bus.Running), 32'd0);
        set_btns(4'b0000);
        tick(2);

        // Asynchronous reset in the middle of a free run with Up=0
        oneshot = 1'b0;
        set_btns(4'b0100);
        tick(3);
        chk("pre_rst_up", 32'(bus.Up), 32'd0);
        set_btns(4'b0001);
        tick(6);
        chk("pre_rst_running", 32'(bus.Running), 32'd1);
        @(posedge Clk);
        #3;
        nReset = 1'b0;
        #1;
        chk("arst_load",    32'(bus.Load),     32'd0);
        chk("arst_ce",      32'(bus.Count_en), 32'd0);
        chk("arst_up",      32'(bus.Up),       32'd1);
        chk("arst_running", 32'(bus.Running),  32'd0);
        chk("arst_done",    32'(bus.Done),     32'd0);
        btns = 4'b0000;
        tick(2);
        @(negedge Clk);
        nReset = 1'b1;
        tick(3);
        chk("post_rst_running", 32'(bus.Running), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
